mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_pkg.sv | 25 ++
 rtl/mem_wb_stage_dmem_sp.sv | 32 +++
 rtl/mem_wb_stage.sv | 96 +++++++++
 3 files changed

// File: rtl/mem_wb_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_wb_pkg : shared pipeline widths and the MEM/WB field record            |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_wb_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              mem2reg;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] rdata;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_dmem_sp.sv
// +----------------------------------------------------------------------------+
// | dmem_sp : single-write-port data array with asynchronous read, no reset    |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_sp
  import mem_wb_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// +----------------------------------------------------------------------------+
// | mem_wb_stage : data-memory access, store-data forwarding and MEM/WB reg    |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_mem_valid,
  input  logic              ex_mem_mem2reg,
  input  logic              ex_mem_memwrite,
  input  logic              ex_mem_regwrite,
  input  logic [DATA_W-1:0] ex_mem_aluout,
  input  logic [DATA_W-1:0] ex_mem_wdata,
  input  logic [REG_W-1:0]  ex_mem_rd,
  input  logic              lwsw_fwd,
  output logic              mem_wb_valid,
  output logic              mem_wb_regwrite,
  output logic [REG_W-1:0]  mem_wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign_err
);

  mem_wb_t           r_q;
  logic              r_err;
  logic [AW-1:0]     w_addr;
  logic              w_misalign;
  logic              w_live;
  logic              w_we;
  logic [DATA_W-1:0] w_store_data;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  assign w_addr     = ex_mem_aluout[AW+1:2];
  assign w_misalign = |ex_mem_aluout[1:0];
  assign w_unused   = &{1'b0, ex_mem_aluout[DATA_W-1:AW+2]};
  assign w_live     = ex_mem_valid & ~stall & ~flush;

  // lw->sw forwarding: the WB-stage load result replaces stale register data
  assign w_store_data = (lwsw_fwd & r_q.valid & r_q.mem2reg) ? r_q.rdata : ex_mem_wdata;
  assign w_we         = rst_n & w_live & ex_mem_memwrite & ~w_misalign;

  dmem_sp #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dmem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_store_data),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= MEM_WB_BUBBLE;
    end else if (stall) begin
      r_q <= r_q;
    end else if (flush) begin
      r_q <= MEM_WB_BUBBLE;
    end else begin
      r_q.valid    <= ex_mem_valid;
      // a misaligned load still reads, but must never reach the register file
      r_q.regwrite <= ex_mem_regwrite & ~(ex_mem_mem2reg & w_misalign);
      r_q.mem2reg  <= ex_mem_mem2reg;
      r_q.rd       <= ex_mem_rd;
      r_q.aluout   <= ex_mem_aluout;
      r_q.rdata    <= w_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_live & (ex_mem_mem2reg | ex_mem_memwrite) & w_misalign) begin
      r_err <= 1'b1;
    end
  end

  assign mem_wb_valid    = r_q.valid;
  assign mem_wb_regwrite = r_q.regwrite & r_q.valid;
  assign mem_wb_rd       = r_q.rd;
  assign wb_data         = r_q.mem2reg ? r_q.rdata : r_q.aluout;
  assign misalign_err    = r_err;

endmodule

`default_nettype wire
